nco_phase: RTL and testbench
============================

NCO_PHASE -- requirements
Module: nco_phase

Interface
REQ-001 SHALL have parameters: none; all widths fixed (phase 18 bits, angle 17 bits unsigned Q1.16 radians, count 16 bits).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  one-cycle pulse requesting a burst; sampled only in IDLE.
REQ-005 cfg_phase_i  input  18  initial phase, units of 2^-18 turn; latched on accepted start.
REQ-006 cfg_step_i  input  18  phase increment per sample, 2^-18 turn; latched on accepted start.
REQ-007 cfg_num_i  input  16  samples in burst; latched on accepted start.
REQ-008 rdy_i  input  1  downstream ready.
REQ-009 val_o  output  1  dat_theta_o/dat_sgn_o/last_o valid.
REQ-010 dat_theta_o  output  17  first-quadrant angle for the sine CORDIC, Q1.16 radians, 0..102944.
REQ-011 dat_sgn_o  output  1  1 = downstream negates the CORDIC result.
REQ-012 last_o  output  1  marks final sample of burst.
REQ-013 busy_o  output  1  high whenever state != IDLE.
REQ-014 done_o  output  1  one-cycle pulse at burst end.

Function
REQ-015 FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-016 IDLE: start_i=1 and cfg_num_i!=0 -> RUN, acc<=cfg_phase_i, cnt<=cfg_num_i; start_i=1 and cfg_num_i==0 -> stay IDLE, done_o pulses next cycle, no samples.
REQ-017 start_i in RUN/DRAIN SHALL be ignored; cfg_* changes after acceptance have no effect.
REQ-018 Pipeline enable en = rdy_i | ~val_o; when en=0 all stage registers, acc and cnt hold (no sample lost or duplicated).
REQ-019 RUN, en=1: issue sample from acc into stage 1, acc<=acc+step mod 2^18, cnt<=cnt-1; issue with cnt==1 carries last=1 and moves to DRAIN.
REQ-020 Stage 1 fold: q=acc[17:16], f=acc[15:0]; q even -> m=f; q odd -> m=65536-f (17 bits); sgn=q[1].
REQ-021 Stage 2: dat_theta_o = (m*102944 + rnd)>>16, 34-bit product, rnd per REQ-030/031; result never exceeds 102944.
REQ-022 Latency: sample issued at edge N appears on val_o after edge N+1 (2-stage), given no stall.
REQ-023 Throughput one sample/cycle while rdy_i=1.
REQ-024 Transfer occurs when val_o&rdy_i; val_o SHALL stay high and outputs stable until transfer.
REQ-025 DRAIN: when both stages empty (last sample transferred) -> IDLE with done_o=1 for exactly that cycle.
REQ-026 cfg_num_i=65535 SHALL produce 65535 samples; acc wrap-around silent.

Reset
REQ-027 rstn low at any time, including mid-burst or mid-stall, SHALL asynchronously force IDLE, acc=0, cnt=0, stage valids=0.
REQ-028 Reset values: val_o=0, dat_theta_o=0, dat_sgn_o=0, last_o=0, busy_o=0, done_o=0; no done_o on reset exit.

Configuration
REQ-029 Macro NCO_PHASE_ROUND_EN selects rounding of stage-2 scale.
REQ-030 Defined: rnd=32768 (round half up).
REQ-031 Undefined: rnd=0 (truncate).

Verification
REQ-032 phase=0, step=16384, num=4, rdy=1 -> theta 0,25736,51472,77208, sgn 0; last on 4th; done_o one cycle after 4th transfer.
REQ-033 phase=65536, step=65536, num=4 -> (theta,sgn) = (102944,0),(0,1),(102944,1),(0,0); wrap to phase 0 on 4th.
REQ-034 phase=1, num=1: ROUND_EN -> theta 2; without -> theta 1; last_o=1 on that sample.
REQ-035 num=3, rdy_i low 5 cycles after first val_o -> outputs held stable, all 3 samples delivered in order, none duplicated.
REQ-036 start with num=0 -> no val_o, done_o pulse next cycle; rstn asserted mid-burst -> all outputs 0 immediately, next start runs cleanly.

Source files
------------

// File: rtl/nco_phase_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nco_phase_if
// Description : Output sample stream of the NCO phase front-end. One
//               sample (first-quadrant angle, sign, last flag) moves per
//               cycle in which val_o and rdy_i are both high.
// Signals     : val_o        - sample valid (producer -> consumer)
//               dat_theta_o  - 17-bit Q1.16 radian angle, 0..102944
//               dat_sgn_o    - 1 = consumer negates the CORDIC result
//               last_o       - final sample of the burst
//               rdy_i        - consumer ready (consumer -> producer)
// Modports    : master (the NCO drives it), slave (the sink)
// Revision    : 1.0 - initial release
// ============================================================================
interface nco_phase_if;
  logic        val_o;
  logic [16:0] dat_theta_o;
  logic        dat_sgn_o;
  logic        last_o;
  logic        rdy_i;

  modport master (
    output val_o,
    output dat_theta_o,
    output dat_sgn_o,
    output last_o,
    input  rdy_i
  );

  modport slave (
    input  val_o,
    input  dat_theta_o,
    input  dat_sgn_o,
    input  last_o,
    output rdy_i
  );
endinterface : nco_phase_if
`default_nettype wire

// File: rtl/nco_phase.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nco_phase
// Description : Burst phase generator feeding a sine CORDIC. A phase
//               accumulator (18-bit, units of 2^-18 turn) is stepped once
//               per issued sample; each phase is folded into the first
//               quadrant (stage 1) and scaled to Q1.16 radians (stage 2).
//               The two-stage pipeline stalls as a whole on back-pressure.
// Ports       : clk          - sole clock, rising edge
//               rstn         - asynchronous active-low reset
//               start_i      - burst request pulse, sampled in IDLE only
//               cfg_phase_i  - initial phase, latched on accepted start
//               cfg_step_i   - phase increment, latched on accepted start
//               cfg_num_i    - burst length, latched on accepted start
//               busy_o       - high whenever the FSM is not IDLE
//               done_o       - one-cycle pulse at burst end
//               dat_if       - output sample stream (master modport)
// Config      : NCO_PHASE_ROUND_EN - defined: stage-2 scale rounds half up;
//               undefined (default): stage-2 scale truncates.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_phase (
  input  wire logic        clk,
  input  wire logic        rstn,
  input  wire logic        start_i,
  input  wire logic [17:0] cfg_phase_i,
  input  wire logic [17:0] cfg_step_i,
  input  wire logic [15:0] cfg_num_i,
  output logic             busy_o,
  output logic             done_o,
  nco_phase_if.master      dat_if
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // pi/2 in Q1.16: round(1.5707963 * 65536) = 102944
  localparam logic [33:0] HALF_PI_Q16 = 34'd102944;
  localparam logic [16:0] QUARTER     = 17'd65536;

`ifdef NCO_PHASE_ROUND_EN
  localparam logic [33:0] SCALE_RND = 34'd32768;
`else
  localparam logic [33:0] SCALE_RND = 34'd0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q,     state_d;
  logic [17:0] acc_q,       acc_d;
  logic [17:0] step_q,      step_d;
  logic [15:0] cnt_q,       cnt_d;
  logic        zdone_q,     zdone_d;    // done pulse for a zero-length burst

  // Stage 1: folded magnitude within the quadrant
  logic        s1_val_q,    s1_val_d;
  logic [16:0] s1_m_q,      s1_m_d;
  logic        s1_sgn_q,    s1_sgn_d;
  logic        s1_last_q,   s1_last_d;

  // Stage 2: scaled angle, drives the output stream directly
  logic        s2_val_q,    s2_val_d;
  logic [16:0] s2_theta_q,  s2_theta_d;
  logic        s2_sgn_q,    s2_sgn_d;
  logic        s2_last_q,   s2_last_d;

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  logic        en;          // whole pipeline advances this cycle
  logic        issue;       // a new sample enters stage 1 this cycle
  logic        drain_empty; // last sample gone, both stages empty
  logic [1:0]  quad;
  logic [15:0] frac;
  logic [16:0] fold_m;
  logic [33:0] prod;
  logic [16:0] scaled;
  logic        w_unused;

  // A stage may move only if the output slot is free or being emptied.
  // Stalling every register together keeps ordering trivially intact.
  assign en    = dat_if.rdy_i | ~s2_val_q;
  assign issue = (state_q == S_RUN) & en;

  // Odd quadrants run backwards from pi/2, so the angle is mirrored:
  // 65536 - f. f = 0 gives the full 65536, hence the 17-bit width.
  assign quad   = acc_q[17:16];
  assign frac   = acc_q[15:0];
  assign fold_m = quad[0] ? (QUARTER - {1'b0, frac}) : {1'b0, frac};

  // m <= 65536, so (m * 102944 + rnd) >> 16 tops out at exactly 102944
  // and always fits 17 bits; bit 33 and the low fraction are discarded.
  assign prod     = ({17'd0, s1_m_q} * HALF_PI_Q16) + SCALE_RND;
  assign scaled   = prod[32:16];
  assign w_unused = ^{prod[33], prod[15:0]};

  assign drain_empty = (state_q == S_DRAIN) & ~s1_val_q & ~s2_val_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    zdone_d    = 1'b0;

    s1_val_d   = s1_val_q;
    s1_m_d     = s1_m_q;
    s1_sgn_d   = s1_sgn_q;
    s1_last_d  = s1_last_q;

    s2_val_d   = s2_val_q;
    s2_theta_d = s2_theta_q;
    s2_sgn_d   = s2_sgn_q;
    s2_last_d  = s2_last_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (cfg_num_i != 16'd0) begin
            state_d = S_RUN;
            acc_d   = cfg_phase_i;
            step_d  = cfg_step_i;
            cnt_d   = cfg_num_i;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (en) begin
          acc_d = acc_q + step_q;   // wraps modulo one turn
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (drain_empty) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pipeline advance; payload registers only load with valid data
    if (en) begin
      s1_val_d = issue;
      if (issue) begin
        s1_m_d    = fold_m;
        s1_sgn_d  = quad[1];
        s1_last_d = (cnt_q == 16'd1);
      end

      s2_val_d = s1_val_q;
      if (s1_val_q) begin
        s2_theta_d = scaled;
        s2_sgn_d   = s1_sgn_q;
        s2_last_d  = s1_last_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      acc_q      <= 18'd0;
      step_q     <= 18'd0;
      cnt_q      <= 16'd0;
      zdone_q    <= 1'b0;
      s1_val_q   <= 1'b0;
      s1_m_q     <= 17'd0;
      s1_sgn_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_val_q   <= 1'b0;
      s2_theta_q <= 17'd0;
      s2_sgn_q   <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      zdone_q    <= zdone_d;
      s1_val_q   <= s1_val_d;
      s1_m_q     <= s1_m_d;
      s1_sgn_q   <= s1_sgn_d;
      s1_last_q  <= s1_last_d;
      s2_val_q   <= s2_val_d;
      s2_theta_q <= s2_theta_d;
      s2_sgn_q   <= s2_sgn_d;
      s2_last_q  <= s2_last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign dat_if.val_o       = s2_val_q;
  assign dat_if.dat_theta_o = s2_theta_q;
  assign dat_if.dat_sgn_o   = s2_sgn_q;
  assign dat_if.last_o      = s2_last_q;

  assign busy_o = (state_q != S_IDLE);
  // Burst end is either the drained DRAIN cycle or the registered
  // acknowledgement of a zero-length request; both are register-driven.
  assign done_o = zdone_q | drain_empty;

endmodule : nco_phase
`default_nettype wire

// File: tb/tb_nco_phase.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_nco_phase
// Description : Self-checking bench for nco_phase. Known-answer bursts come
//               from a vector table; further bursts use a reference model.
//               Expected samples are queued when a burst is started and
//               popped by a monitor on each transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_phase;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i;
  logic [17:0] cfg_phase_i;
  logic [17:0] cfg_step_i;
  logic [15:0] cfg_num_i;
  logic        busy_o;
  logic        done_o;

  nco_phase_if bus ();

  nco_phase dut (
    .clk         (clk),
    .rstn        (rstn),
    .start_i     (start_i),
    .cfg_phase_i (cfg_phase_i),
    .cfg_step_i  (cfg_step_i),
    .cfg_num_i   (cfg_num_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dat_if      (bus)
  );

  always #5 clk = ~clk;

`ifdef NCO_PHASE_ROUND_EN
  localparam logic [33:0] TB_RND = 34'd32768;
  localparam logic [16:0] ONE_LSB_THETA = 17'd2;
`else
  localparam logic [33:0] TB_RND = 34'd0;
  localparam logic [16:0] ONE_LSB_THETA = 17'd1;
`endif

  typedef struct packed {
    logic [16:0] theta;
    logic        sgn;
    logic        last;
  } exp_t;

  typedef struct packed {
    logic [17:0]       phase;
    logic [17:0]       step;
    logic [15:0]       num;
    logic [3:0][16:0]  th;
    logic [3:0]        sg;
  } vec_t;

  exp_t sbq[$];
  int   nchk  = 0;
  int   npass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  // Reference: fold phase into first quadrant, scale by pi/2 in Q1.16
  function automatic exp_t model(input logic [17:0] acc, input logic lst);
    logic [16:0] m;
    logic [33:0] p;
    exp_t        e;
    m = acc[16] ? (17'd65536 - {1'b0, acc[15:0]}) : {1'b0, acc[15:0]};
    p = ({17'd0, m} * 34'd102944) + TB_RND;
    e.theta = p[32:16];
    e.sgn   = acc[17];
    e.last  = lst;
    return e;
  endfunction

  task automatic push_model(input logic [17:0] ph, input logic [17:0] st, input logic [15:0] n);
    logic [17:0] acc;
    acc = ph;
    for (int i = 0; i < int'(n); i++) begin
      sbq.push_back(model(acc, (i == int'(n) - 1)));
      acc = acc + st;
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: scoreboard pops, stall stability, done-after-last timing
  // --------------------------------------------------------------------------
  logic        prev_val = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [18:0] prev_dat = '0;
  bit          pend_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      prev_val  = 1'b0;
      pend_done = 1'b0;
    end else begin
      if (prev_val && !prev_rdy)
        chk("stall_hold", {bus.val_o, bus.dat_theta_o, bus.dat_sgn_o, bus.last_o},
            {1'b1, prev_dat});
      if (pend_done) begin
        chk("done_after_last", done_o, 1'b1);
        pend_done = 1'b0;
      end
      if (bus.val_o && bus.rdy_i) begin
        if (sbq.size() == 0) begin
          chk("unexpected_sample", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("theta", bus.dat_theta_o, e.theta);
          chk("sgn_last", {bus.dat_sgn_o, bus.last_o}, {e.sgn, e.last});
          if (bus.last_o) pend_done = 1'b1;
        end
      end
      prev_val = bus.val_o;
      prev_rdy = bus.rdy_i;
      prev_dat = {bus.dat_theta_o, bus.dat_sgn_o, bus.last_o};
    end
  end

  // --------------------------------------------------------------------------
  // Burst driver. mode 0: rdy=1; 1: random rdy; 2: rdy low 5 cycles after
  // first val_o. poke=1 fires a spurious start with junk cfg mid-burst.
  // --------------------------------------------------------------------------
  task automatic run_burst(input logic [17:0] ph, input logic [17:0] st,
                           input logic [15:0] n, input int mode, input bit poke);
    int cyc   = 0;
    int maxc  = int'(n) * 4 + 40;
    int stall = 5;
    bit seen  = 0;
    bit got   = 0;
    @(posedge clk); #1;
    start_i = 1'b1; cfg_phase_i = ph; cfg_step_i = st; cfg_num_i = n;
    bus.rdy_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cfg_phase_i = 18'($urandom); cfg_step_i = 18'($urandom); cfg_num_i = 16'($urandom);
    while (!got && cyc < maxc) begin
      if (done_o) begin
        got = 1;
      end else begin
        if (bus.val_o) seen = 1;
        case (mode)
          0:       bus.rdy_i = 1'b1;
          1:       bus.rdy_i = 1'($urandom_range(0, 1));
          default: if (seen && stall > 0) begin bus.rdy_i = 1'b0; stall--; end
                   else bus.rdy_i = 1'b1;
        endcase
        start_i = (poke && cyc == 3 && busy_o);
        @(posedge clk); #1;
        cyc++;
      end
    end
    start_i   = 1'b0;
    bus.rdy_i = 1'b1;
    chk("done_seen", got, 1'b1);
    chk("queue_drained", sbq.size(), 0);
    @(posedge clk); #1;
    chk("done_one_cycle_idle", {done_o, busy_o}, 2'b00);
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  vec_t vecs[3];

  initial begin
    vecs[0] = '{phase: 18'd0, step: 18'd16384, num: 16'd4,
                th: {17'd77208, 17'd51472, 17'd25736, 17'd0}, sg: 4'b0000};
    vecs[1] = '{phase: 18'd65536, step: 18'd65536, num: 16'd4,
                th: {17'd0, 17'd102944, 17'd0, 17'd102944}, sg: 4'b0110};
    vecs[2] = '{phase: 18'd1, step: 18'd0, num: 16'd1,
                th: {17'd0, 17'd0, 17'd0, ONE_LSB_THETA}, sg: 4'b0000};

    rstn = 1'b1; start_i = 1'b0; cfg_phase_i = '0; cfg_step_i = '0; cfg_num_i = '0;
    bus.rdy_i = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk("reset_outputs", {bus.val_o, bus.dat_theta_o, bus.dat_sgn_o, bus.last_o, busy_o, done_o}, '0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    chk("no_done_on_reset_exit", {done_o, busy_o}, 2'b00);

    // Known-answer bursts
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < int'(vecs[v].num); i++)
        sbq.push_back('{theta: vecs[v].th[i], sgn: vecs[v].sg[i],
                        last: (i == int'(vecs[v].num) - 1)});
      run_burst(vecs[v].phase, vecs[v].step, vecs[v].num, 0, 1'b0);
    end

    // Back-pressure: 3 samples, rdy low 5 cycles once output appears
    push_model(18'd1000, 18'd30000, 16'd3);
    run_burst(18'd1000, 18'd30000, 16'd3, 2, 1'b0);

    // Zero-length burst: done next cycle, no samples
    @(posedge clk); #1;
    start_i = 1'b1; cfg_num_i = 16'd0; cfg_phase_i = 18'd5; cfg_step_i = 18'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("zero_num_done", {done_o, busy_o, bus.val_o}, 3'b100);
    @(posedge clk); #1;
    chk("zero_num_after", {done_o, busy_o, bus.val_o}, 3'b000);

    // Random bursts with random back-pressure and ignored restarts
    for (int r = 0; r < 6; r++) begin
      logic [17:0] ph, st;
      logic [15:0] n;
      ph = 18'($urandom); st = 18'($urandom);
      n  = (r == 5) ? 16'd200 : 16'($urandom_range(1, 40));
      push_model(ph, st, n);
      run_burst(ph, st, n, 1, 1'b1);
    end

    // Reset mid-burst
    push_model(18'd0, 18'd5000, 16'd10);
    @(posedge clk); #1;
    start_i = 1'b1; cfg_phase_i = 18'd0; cfg_step_i = 18'd5000; cfg_num_i = 16'd10;
    bus.rdy_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("reset_midburst", {bus.val_o, bus.dat_theta_o, bus.dat_sgn_o, bus.last_o, busy_o, done_o}, '0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_quiet", {done_o, busy_o, bus.val_o}, 3'b000);

    // Clean burst after reset
    push_model(18'd200000, 18'd12345, 16'd8);
    run_burst(18'd200000, 18'd12345, 16'd8, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule : tb_nco_phase
`default_nettype wire
